// File: rtl/fb_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_port_arbiter_if
// Purpose  : Bundles the reader, writer and RAM-side signals of the
//            framebuffer port arbiter.
// Ports    : disp_en/rd_req/rd_addr -> rd_data/rd_valid  (VGA reader)
//            wr_valid/wr_addr/wr_data -> wr_ready/wr_idle (pixel writer)
//            fifo_level, starve_err                       (status)
//            mem_addr/mem_data/mem_wren <- mem_q           (single-port RAM)
//            Modport slave = arbiter view, master = surrounding logic.
// Revision : 1.0  initial release
// ============================================================================
interface fb_port_arbiter_if #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              disp_en;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_idle;
  logic [c_LVL_W-1:0] fifo_level;
  logic              starve_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  disp_en, rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_q,
    output rd_data, rd_valid, wr_ready, wr_idle, fifo_level, starve_err,
           mem_addr, mem_data, mem_wren
  );

  modport master (
    output disp_en, rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_q,
    input  rd_data, rd_valid, wr_ready, wr_idle, fifo_level, starve_err,
           mem_addr, mem_data, mem_wren
  );
endinterface
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_port_arbiter
// Purpose  : Shares one single-port framebuffer RAM between the VGA scan-out
//            reader (absolute priority) and a pixel writer whose requests are
//            buffered in a small FIFO and drained into free cycles.
// Ports    : clk  - 50 MHz clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - fb_port_arbiter_if.slave (reader, writer, status, RAM)
// Revision : 1.0  initial release
// ============================================================================
module fb_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  fb_port_arbiter_if.slave      bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [c_LVL_W-1:0] c_FULL       = c_LVL_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_t;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_LVL_W-1:0] r_level;

  // Read return pipe: bit k set means a read granted k+1 cycles ago
  logic [RAM_LAT:0]   r_vpipe;
  logic [DATA_W-1:0]  r_rd_data;

  logic [c_CNT_W-1:0] r_starve_cnt;
  logic               r_starve_err;

  grant_t             w_grant;
  logic               w_fifo_empty;
  logic               w_wr_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_starving;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  assign w_fifo_empty = (r_level == '0);
  // Full is judged on the current level only, so a pop in the same cycle
  // never lets a push slip into a full FIFO.
  assign w_wr_ready   = (r_level != c_FULL) & ~rst;
  assign w_push       = bus.wr_valid & w_wr_ready;
  assign w_pop        = (w_grant == GNT_WRITE);

  // Per-cycle grant: the reader always wins, the FIFO head takes the rest.
  always_comb begin
    w_grant = GNT_IDLE;
    if (!rst) begin
      if (bus.rd_req && bus.disp_en) begin
        w_grant = GNT_READ;
      end else if (!w_fifo_empty) begin
        w_grant = GNT_WRITE;
      end
    end
  end

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_data = '0;
    bus.mem_wren = 1'b0;
    unique case (w_grant)
      GNT_READ: begin
        bus.mem_addr = bus.rd_addr;
      end
      GNT_WRITE: begin
        bus.mem_addr = r_fifo_addr[r_rptr];
        bus.mem_data = r_fifo_data[r_rptr];
        bus.mem_wren = 1'b1;
      end
      default: begin
        bus.mem_wren = 1'b0;
      end
    endcase
  end

  // Storage needs no reset; validity is carried by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= bus.wr_addr;
      r_fifo_data[r_wptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // mem_q is valid RAM_LAT cycles after the grant; rd_valid follows one
  // cycle later together with the captured pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe   <= '0;
      r_rd_data <= '0;
    end else begin
      r_vpipe <= {r_vpipe[RAM_LAT-1:0], (w_grant == GNT_READ)};
      if (r_vpipe[RAM_LAT-1]) begin
        r_rd_data <= bus.mem_q;
      end
    end
  end

  // Starvation: consecutive cycles where a write waits behind a read.
  assign w_starving = ~w_fifo_empty & (w_grant == GNT_READ);

  always_comb begin
    w_cnt_nxt = r_starve_cnt;
    if (!w_starving) begin
      w_cnt_nxt = '0;
    end else if (r_starve_cnt != c_STARVE_MAX) begin
      w_cnt_nxt = r_starve_cnt + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_starve_err <= 1'b0;
    end else begin
      r_starve_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == c_STARVE_MAX) begin
        r_starve_err <= 1'b1;
      end
    end
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_vpipe[RAM_LAT];
  assign bus.wr_ready   = w_wr_ready;
  assign bus.wr_idle    = rst | (w_fifo_empty & ~w_push);
  assign bus.fifo_level = r_level;
  assign bus.starve_err = r_starve_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fb_port_arbiter
// Purpose  : Self-checking bench for fb_port_arbiter with a single-port RAM
//            model, a read/write scoreboard and a per-cycle vector table.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_port_arbiter;
  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus();

  fb_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RAM_LAT(1), .STARVE_MAX(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Single-port RAM model, one cycle read latency, with a preload port
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a  = '0;
  logic [DW-1:0] pre_d  = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= ram[bus.mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int max_level = 0;
  logic mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int due; } rd_e_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int acc; } wr_e_t;
  rd_e_t rdq[$];
  wr_e_t wq[$];
  rd_e_t r_e;
  wr_e_t w_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Drive one cycle of stimulus; a granted read queues its expected pixel
  task automatic drive(input logic de, input logic rq, input logic [AW-1:0] ra,
                       input logic [DW-1:0] rexp, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    rd_e_t e;
    bus.disp_en  = de;
    bus.rd_req   = rq;
    bus.rd_addr  = ra;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    if (de && rq && !rst) begin
      e.d = rexp;
      e.due = cyc + 2;
      rdq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    while (!bus.wr_idle && k < 40) begin
      tick();
      sample();
      k++;
    end
    chk("wr_idle_reached", {31'd0, bus.wr_idle}, 32'd1);
    tick();
  endtask

  // Monitor: write and read scoreboards plus read-priority check
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_wren) begin
        if (wq.size() == 0) begin
          chk("unexpected_mem_wren", 32'd1, 32'd0);
        end else begin
          w_e = wq.pop_front();
          chk("wr_issue_addr", {13'd0, bus.mem_addr}, {13'd0, w_e.a});
          chk("wr_issue_data", {24'd0, bus.mem_data}, {24'd0, w_e.d});
          chk("wr_after_accept", {31'd0, (cyc > w_e.acc)}, 32'd1);
        end
      end
      if (bus.disp_en && bus.rd_req && !rst) begin
        chk("rd_grant_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("rd_grant_addr", {13'd0, bus.mem_addr}, {13'd0, bus.rd_addr});
      end
      if (bus.rd_valid) begin
        if (rdq.size() == 0) begin
          chk("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          r_e = rdq.pop_front();
          chk("rd_data", {24'd0, bus.rd_data}, {24'd0, r_e.d});
          chk("rd_cycle", cyc, r_e.due);
        end
      end
      if (bus.wr_valid && bus.wr_ready) begin
        w_e.a = bus.wr_addr;
        w_e.d = bus.wr_data;
        w_e.acc = cyc;
        wq.push_back(w_e);
      end
      if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
    end
  end

  typedef struct {
    logic de; logic rq; logic [AW-1:0] ra; logic [DW-1:0] rexp;
    logic wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic e_wren; logic [AW-1:0] e_maddr; logic [DW-1:0] e_mdata;
    logic e_ready; logic e_idle; logic [2:0] e_level;
  } vec_t;

  function automatic vec_t mk(logic de, logic rq, logic [AW-1:0] ra, logic [DW-1:0] rexp,
                              logic wv, logic [AW-1:0] wa, logic [DW-1:0] wd,
                              logic e_wren, logic [AW-1:0] e_maddr, logic [DW-1:0] e_mdata,
                              logic e_ready, logic e_idle, logic [2:0] e_level);
    vec_t v;
    v.de = de; v.rq = rq; v.ra = ra; v.rexp = rexp;
    v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_wren = e_wren; v.e_maddr = e_maddr; v.e_mdata = e_mdata;
    v.e_ready = e_ready; v.e_idle = e_idle; v.e_level = e_level;
    return v;
  endfunction

  vec_t vt[11];

  initial begin
    int idx;
    // Reads block the writer for 5 cycles so the FIFO fills, then drain.
    vt[0]  = mk(1, 1, 100, 8'h5C, 1, 0, 8'hA0, 0, 100, 8'h00, 1, 0, 3'd0);
    vt[1]  = mk(1, 1, 100, 8'h5C, 1, 1, 8'hA1, 0, 100, 8'h00, 1, 0, 3'd1);
    vt[2]  = mk(1, 1, 100, 8'h5C, 1, 2, 8'hA2, 0, 100, 8'h00, 1, 0, 3'd2);
    vt[3]  = mk(1, 1, 100, 8'h5C, 1, 3, 8'hA3, 0, 100, 8'h00, 1, 0, 3'd3);
    vt[4]  = mk(1, 1, 100, 8'h5C, 1, 4, 8'hA4, 0, 100, 8'h00, 0, 0, 3'd4);
    vt[5]  = mk(0, 1, 100, 8'h00, 1, 4, 8'hA4, 1, 0,   8'hA0, 0, 0, 3'd4);
    vt[6]  = mk(0, 0, 0,   8'h00, 1, 4, 8'hA4, 1, 1,   8'hA1, 1, 0, 3'd3);
    vt[7]  = mk(0, 0, 0,   8'h00, 0, 0, 8'h00, 1, 2,   8'hA2, 1, 0, 3'd3);
    vt[8]  = mk(0, 0, 0,   8'h00, 0, 0, 8'h00, 1, 3,   8'hA3, 1, 0, 3'd2);
    vt[9]  = mk(0, 0, 0,   8'h00, 0, 0, 8'h00, 1, 4,   8'hA4, 1, 0, 3'd1);
    vt[10] = mk(0, 0, 0,   8'h00, 0, 0, 8'h00, 0, 0,   8'h00, 1, 1, 3'd0);

    // ---------------- reset with all requests asserted ----------------
    bus.disp_en = 1; bus.rd_req = 1; bus.rd_addr = 5;
    bus.wr_valid = 1; bus.wr_addr = 9; bus.wr_data = 8'h33;
    pre_we = 1; pre_a = 100; pre_d = 8'h5C;
    tick();
    pre_a = 7; pre_d = 8'h00;
    sample();
    chk("rst_mem_wren", {31'd0, bus.mem_wren}, 32'd0);
    chk("rst_mem_addr", {13'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_data", {24'd0, bus.mem_data}, 32'd0);
    chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    chk("rst_wr_idle",  {31'd0, bus.wr_idle},  32'd1);
    tick();
    pre_we = 0;
    tick();
    rst = 0;
    mon_en = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("post_rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("post_rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    chk("post_rst_level", {29'd0, bus.fifo_level}, 32'd0);
    chk("post_rst_starve", {31'd0, bus.starve_err}, 32'd0);
    chk("post_rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    tick();

    // ---------------- vector table ----------------
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].de, vt[i].rq, vt[i].ra, vt[i].rexp, vt[i].wv, vt[i].wa, vt[i].wd);
      sample();
      chk($sformatf("vec%0d_mem_wren", i), {31'd0, bus.mem_wren}, {31'd0, vt[i].e_wren});
      chk($sformatf("vec%0d_mem_addr", i), {13'd0, bus.mem_addr}, {13'd0, vt[i].e_maddr});
      if (!(vt[i].de && vt[i].rq))
        chk($sformatf("vec%0d_mem_data", i), {24'd0, bus.mem_data}, {24'd0, vt[i].e_mdata});
      chk($sformatf("vec%0d_wr_ready", i), {31'd0, bus.wr_ready}, {31'd0, vt[i].e_ready});
      chk($sformatf("vec%0d_wr_idle", i), {31'd0, bus.wr_idle}, {31'd0, vt[i].e_idle});
      chk($sformatf("vec%0d_level", i), {29'd0, bus.fifo_level}, {29'd0, vt[i].e_level});
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // ---------------- reads every other cycle, 8 streaming writes ----------------
    idx = 0;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      drive(1, (k % 2) == 0, 100, 8'h5C, 1, AW'(300 + idx), DW'(8'h40 + idx));
      sample();
      if (bus.wr_ready) idx++;
      tick();
    end
    chk("stream_all_accepted", idx, 8);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, AW'(300 + i), DW'(8'h40 + i), 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("max_level_le_depth", {31'd0, (max_level <= DEPTH)}, 32'd1);

    // ---------------- coherency: same-cycle write and read ----------------
    drive(1, 1, 7, 8'h00, 1, 7, 8'h11);
    tick();
    wait_idle();
    drive(1, 1, 7, 8'h11, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    sample();
    chk("rd_data_hold", {24'd0, bus.rd_data}, 32'h11);
    tick();

    // ---------------- starvation with continuous reads ----------------
    for (int k = 0; k <= 16; k++) begin
      drive(1, 1, 100, 8'h5C, k == 0, 600, 8'h77);
      sample();
      if (k == 15) chk("starve_before_max", {31'd0, bus.starve_err}, 32'd0);
      if (k == 16) chk("starve_at_max", {31'd0, bus.starve_err}, 32'd1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    sample();
    chk("starve_sticky", {31'd0, bus.starve_err}, 32'd1);
    chk("starve_drained", {29'd0, bus.fifo_level}, 32'd0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    sample();
    chk("starve_cleared", {31'd0, bus.starve_err}, 32'd0);
    tick();

    // ---------------- reset with writes queued and reads in flight ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 100, 8'h5C, 1, AW'(500 + i), DW'(i));
      tick();
    end
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    wq.delete();
    for (int i = rdq.size() - 1; i >= 0; i--) if (rdq[i].due > cyc) rdq.delete(i);
    sample();
    chk("rst_mid_mem_wren", {31'd0, bus.mem_wren}, 32'd0);
    tick();
    tick();
    rst = 0;
    sample();
    chk("rst_mid_level", {29'd0, bus.fifo_level}, 32'd0);
    chk("rst_mid_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("rst_mid_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    tick();
    repeat (6) tick();

    chk("rd_scoreboard_empty", rdq.size(), 0);
    chk("wr_scoreboard_empty", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, expected end of test");
    $fatal(1);
  end

endmodule
`default_nettype wire
